// File: rtl/sccb_write_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sccb_write_ctrl : 4-byte SCCB register write master (ID+W, addr hi/lo, val)
// Rev 1.0
// ---------------------------------------------------------------------------
module sccb_write_ctrl #(
  parameter logic [6:0] DEVICE_ID = 7'h3C,
  parameter int         QTR_CNT   = 50
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int CW = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BYTE  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   shreg;
  logic          tick;

  assign tick = (qcnt == CW'(QTR_CNT - 1));

  // On each tick the bus levels for the quarter being entered are registered,
  // so scl/sda_oe only ever move on quarter boundaries.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      qcnt     <= '0;
      qtr      <= 2'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shreg    <= 32'd0;
      cfg_end  <= 1'b0;
      busy     <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      cfg_end <= 1'b0;
      if (state == IDLE || state == DONE || tick) qcnt <= '0;
      else                                        qcnt <= qcnt + 1'b1;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            shreg    <= {DEVICE_ID, 1'b0, cfg_data};
            ack_err  <= 1'b0;
            busy     <= 1'b1;
            qtr      <= 2'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            state    <= START;
          end
        end

        START: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0:    sda_oe <= 1'b1;
            2'd1:    scl    <= 1'b0;
            2'd2:    ;
            default: begin
              sda_oe <= ~shreg[31];
              state  <= BYTE;
            end
          endcase
        end

        BYTE: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0:    scl <= 1'b1;
            2'd1:    ;
            2'd2:    scl <= 1'b0;
            default: begin
              shreg   <= {shreg[30:0], 1'b0};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                sda_oe <= 1'b0;
                state  <= ACK;
              end else begin
                sda_oe <= ~shreg[30];
              end
            end
          endcase
        end

        // The slave's answer is recorded but never aborts the write.
        ACK: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0:    scl <= 1'b1;
            2'd1:    ;
            2'd2:    begin
              scl     <= 1'b0;
              ack_err <= ack_err | sda_i;
            end
            default: begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                sda_oe <= 1'b1;
                state  <= STOP;
              end else begin
                sda_oe <= ~shreg[31];
                state  <= BYTE;
              end
            end
          endcase
        end

        STOP: if (tick) begin
          qtr <= qtr + 2'd1;
          case (qtr)
            2'd0:    scl    <= 1'b1;
            2'd1:    sda_oe <= 1'b0;
            2'd2:    ;
            default: begin
              cfg_end <= 1'b1;
              state   <= DONE;
            end
          endcase
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
